sprite_loader: RTL and testbench

// Write side of the frog/car sprite Memory blocks. Receives a byte stream from the UART

---
 rtl/sprite_loader.sv | 115 +++++++++++
 tb/tb_sprite_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
// Sprite loader: frames a UART byte stream (SYNC, SEL, HI/LO pixel pairs, CHK) into
// RGB333 pixel writes for the frog/car sprite memories, validating an XOR checksum.
module sprite_loader #(
    parameter int          TILE_SIZE = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_write_en,
    output logic [9:0]  o_write_addr,
    output logic [8:0]  o_write_data,
    output logic        o_mem_select,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error
);

    localparam int         PIXEL_COUNT = TILE_SIZE * TILE_SIZE;
    localparam logic [9:0] LAST_ADDR   = 10'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        PIX_HI,
        PIX_LO,
        CHECK
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  pix_addr;
    logic [7:0]  checksum;
    logic        hi_bit;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_Rx_DV) begin
            case (state)
                IDLE:    if (i_Rx_Byte == SYNC_BYTE) state_next = SEL;
                SEL:     state_next = (i_Rx_Byte[7:1] == 7'd0) ? PIX_HI : IDLE;
                PIX_HI:  state_next = PIX_LO;
                PIX_LO:  state_next = (pix_addr == LAST_ADDR) ? CHECK : PIX_HI;
                CHECK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Pixel data path; the address counter stops at the last pixel and the
    // written address/data hold until the next LO byte arrives.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_write_en   <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
            o_mem_select <= 1'b0;
            o_Done       <= 1'b0;
            o_Error      <= 1'b0;
            pix_addr     <= '0;
            checksum     <= '0;
            hi_bit       <= 1'b0;
        end else begin
            o_write_en <= 1'b0;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
            if (i_Rx_DV) begin
                case (state)
                    SEL: begin
                        if (i_Rx_Byte[7:1] == 7'd0) begin
                            o_mem_select <= i_Rx_Byte[0];
                            pix_addr     <= '0;
                            checksum     <= '0;
                        end else begin
                            o_Error <= 1'b1;
                        end
                    end
                    PIX_HI: begin
                        hi_bit   <= i_Rx_Byte[0];
                        checksum <= checksum ^ i_Rx_Byte;
                    end
                    PIX_LO: begin
                        o_write_en   <= 1'b1;
                        o_write_addr <= pix_addr;
                        o_write_data <= {hi_bit, i_Rx_Byte};
                        checksum     <= checksum ^ i_Rx_Byte;
                        if (pix_addr != LAST_ADDR) begin
                            pix_addr <= pix_addr + 10'd1;
                        end
                    end
                    CHECK: begin
                        if (i_Rx_Byte == checksum) begin
                            o_Done <= 1'b1;
                        end else begin
                            o_Error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: stimulus pushes expected writes and
// done/error events; a negedge monitor pops and compares whenever the DUT emits one.
module tb_sprite_loader;

    typedef struct {
        logic [9:0] addr;
        logic [8:0] data;
        logic       sel;
        int         cyc;
    } wr_t;

    typedef struct {
        logic done;
        logic err;
        int   cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxDv = 1'b0;
    logic [7:0] rxByte = 8'h00;
    logic       writeEn;
    logic [9:0] writeAddr;
    logic [8:0] writeData;
    logic       memSelect;
    logic       busy;
    logic       done;
    logic       error;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         lastDoneCyc = -1;
    logic [7:0] runChk;
    wr_t        wrQ[$];
    ev_t        evQ[$];

    sprite_loader #(.TILE_SIZE(32), .SYNC_BYTE(8'hA5)) dut (
        .i_Clk        (clk),
        .i_Reset      (reset),
        .i_Rx_DV      (rxDv),
        .i_Rx_Byte    (rxByte),
        .o_write_en   (writeEn),
        .o_write_addr (writeAddr),
        .o_write_data (writeData),
        .o_mem_select (memSelect),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One byte strobe, sampled at the next rising edge; returns just after it.
    task automatic applyStimulus(input logic [7:0] b);
        rxDv   = 1'b1;
        rxByte = b;
        @(posedge clk);
        #1;
        rxDv   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void pixelBytes(input int mode, input int k, output logic [7:0] hi,
                                       output logic [7:0] lo, output logic [8:0] data);
        logic [9:0] kb;
        kb = 10'(k);
        case (mode)
            0: begin hi = {7'd0, kb[8]};  lo = kb[7:0];  data = kb[8:0];           end
            1: begin hi = 8'h01;          lo = 8'hC0;    data = 9'h1C0;            end
            default: begin hi = {kb[6:0], kb[8]}; lo = ~kb[7:0]; data = {kb[8], ~kb[7:0]}; end
        endcase
    endfunction

    task automatic sendPixel(input int mode, input int k, input logic sel, input bit gap);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [8:0] data;
        wr_t        e;
        pixelBytes(mode, k, hi, lo, data);
        runChk = runChk ^ hi ^ lo;
        applyStimulus(hi);
        if (gap) idleCycles(1);
        e.addr = 10'(k);
        e.data = data;
        e.sel  = sel;
        e.cyc  = cyc + 1;
        wrQ.push_back(e);
        applyStimulus(lo);
    endtask

    task automatic sendFrame(input logic [7:0] selByte, input int mode, input bit corruptChk);
        ev_t ev;
        runChk = 8'h00;
        applyStimulus(8'hA5);
        applyStimulus(selByte);
        for (int k = 0; k < 1024; k++) begin
            sendPixel(mode, k, selByte[0], (mode == 2) && (k % 3 == 0));
        end
        ev.done = !corruptChk;
        ev.err  = corruptChk;
        ev.cyc  = cyc + 1;
        evQ.push_back(ev);
        applyStimulus(corruptChk ? ~runChk : runChk);
    endtask

    // Monitor: every write strobe and every done/error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            if (wrQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected write: addr %0h data %0h, expected no write", writeAddr, writeData);
            end else begin
                wr_t e;
                e = wrQ.pop_front();
                checkOutput("write_addr", 32'(writeAddr), 32'(e.addr));
                checkOutput("write_data", 32'(writeData), 32'(e.data));
                checkOutput("mem_select", 32'(memSelect), 32'(e.sel));
                checkOutput("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done === 1'b1 || error === 1'b1) begin
            if (done === 1'b1) lastDoneCyc = cyc;
            if (evQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected status: done %0b error %0b, expected none", done, error);
            end else begin
                ev_t ev;
                ev = evQ.pop_front();
                checkOutput("done", 32'(done), 32'(ev.done));
                checkOutput("error", 32'(error), 32'(ev.err));
                checkOutput("status_cycle", 32'(cyc), 32'(ev.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " write_en"},   32'(writeEn),   32'h0);
        checkOutput({tag, " write_addr"}, 32'(writeAddr), 32'h0);
        checkOutput({tag, " write_data"}, 32'(writeData), 32'h0);
        checkOutput({tag, " mem_select"}, 32'(memSelect), 32'h0);
        checkOutput({tag, " busy"},       32'(busy),      32'h0);
        checkOutput({tag, " done"},       32'(done),      32'h0);
        checkOutput({tag, " error"},      32'(error),     32'h0);
    endtask

    initial begin
        int  startCyc;
        ev_t ev;

        reset = 1'b1;
        idleCycles(2);
        checkAllZero("reset");
        reset = 1'b0;
        idleCycles(1);

        $display("[TB] frog frame, ramp pixels");
        sendFrame(8'h00, 0, 1'b0);

        $display("[TB] car frame, constant 1C0");
        sendFrame(8'h01, 1, 1'b0);

        $display("[TB] frame with inverted checksum");
        sendFrame(8'h00, 0, 1'b1);

        $display("[TB] bad select byte, then gapped car frame");
        applyStimulus(8'hA5);
        checkOutput("busy after sync", 32'(busy), 32'h1);
        ev.done = 1'b0;
        ev.err  = 1'b1;
        ev.cyc  = cyc + 1;
        evQ.push_back(ev);
        applyStimulus(8'h07);
        checkOutput("busy after bad sel", 32'(busy), 32'h0);
        idleCycles(2);
        sendFrame(8'h01, 2, 1'b0);
        idleCycles(2);

        $display("[TB] idle noise, then reset mid-frame");
        applyStimulus(8'h00);
        checkOutput("busy idle 00", 32'(busy), 32'h0);
        applyStimulus(8'hFF);
        checkOutput("busy idle FF", 32'(busy), 32'h0);
        applyStimulus(8'hA4);
        checkOutput("busy idle A4", 32'(busy), 32'h0);
        runChk = 8'h00;
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        for (int k = 0; k < 300; k++) begin
            sendPixel(1, k, 1'b1, 1'b0);
        end
        applyStimulus(8'h01);
        rxDv   = 1'b1;
        rxByte = 8'hC0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        rxDv   = 1'b0;
        reset  = 1'b0;
        checkAllZero("mid-frame reset");
        idleCycles(1);
        sendFrame(8'h00, 0, 1'b0);

        $display("[TB] back-to-back frame");
        startCyc = cyc;
        sendFrame(8'h01, 0, 1'b0);
        idleCycles(4);
        checkOutput("b2b done latency", 32'(lastDoneCyc - startCyc), 32'd2051);
        checkOutput("writes outstanding", 32'(wrQ.size()), 32'd0);
        checkOutput("status outstanding", 32'(evQ.size()), 32'd0);
        checkOutput("busy at end", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
